booth_mult_seq: RTL and testbench

//  Iterative radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH two's-complement product.

---
 rtl/booth_mult_seq.sv | 120 ++++++++++++
 tb/tb_booth_mult_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, one digit per clock.
// Define BOOTH_UNSIGNED_EN to add the op_signed_i port and unsigned mode.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
`ifdef BOOTH_UNSIGNED_EN
  input  logic                 op_signed_i,
`endif
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned PW  = WIDTH + 2;
  localparam int unsigned BW  = WIDTH + 3;
  localparam int unsigned PRW = 2 * WIDTH;
  localparam int unsigned CW  = $clog2(WIDTH / 2 + 2);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic signed [PW-1:0]  a_q, a_d;
  logic [BW-1:0]         b_q, b_d;
  logic [PRW-1:0]        acc_q, acc_d;
  logic [PRW-1:0]        prod_q, prod_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         last_q, last_d;

  logic                  sgn_op;
  logic signed [PW-1:0]  pp;
  logic [PRW-1:0]        pp_ext;
  logic [PRW-1:0]        pp_sh;

`ifdef BOOTH_UNSIGNED_EN
  assign sgn_op = op_signed_i;
`else
  assign sgn_op = 1'b1;
`endif

  // Multiplier is shifted right two bits per digit, so the window is always b_q[2:0].
  always_comb begin
    pp = '0;
    case (b_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q <<< 1;
      3'b100:         pp = -(a_q <<< 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;
    endcase
    pp_ext = {{(PRW - PW){pp[PW-1]}}, pp};
    pp_sh  = pp_ext << {cnt_q, 1'b0};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    in_ready_o  = (state_q == StIdle);
    out_valid_o = (state_q == StDone);
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d     = {{2{sgn_op & mcand_i[WIDTH-1]}}, mcand_i};
          b_d     = {{2{sgn_op & mplier_i[WIDTH-1]}}, mplier_i, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          // Unsigned needs one extra digit to absorb the zero-extended top bit.
          last_d  = sgn_op ? CW'(WIDTH / 2 - 1) : CW'(WIDTH / 2);
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = acc_q + pp_sh;
        b_d   = {{2{b_q[BW-1]}}, b_q[BW-1:2]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == last_q) begin
          prod_d  = acc_q + pp_sh;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign product_o = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=8; unsigned-mode test runs when
// BOOTH_UNSIGNED_EN is defined.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        op_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mcand_i     (mcand),
    .mplier_i    (mplier),
`ifdef BOOTH_UNSIGNED_EN
    .op_signed_i (op_signed),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .product_o   (product)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; lat = cycles from accept edge to out_valid; p sampled at handshake.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall_pct,
                        output logic [15:0] p, output int lat, output bit to);
    int guard;
    to = 1'b0;
    lat = 0;
    p = '0;
    mcand = a;
    mplier = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!in_ready) begin
      to = 1'b1;
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    mcand = 8'hA5;
    mplier = 8'h5A;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!out_valid) begin
      to = 1'b1;
      return;
    end
    guard = 0;
    forever begin
      out_ready = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
      p = product;
      if (out_ready || guard > 30) begin
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        break;
      end
      step();
      guard++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mcand = '0;
    mplier = '0;
    op_signed = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_product: got %h want 0000", product);
    end
  endtask

  task automatic test_basic();
    logic [15:0] p;
    int lat;
    bit to;
    run_op(8'd7, 8'd3, 0, p, lat, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL basic_timeout: got %b want 0", to);
    end
    checks++;
    if (p !== 16'h0015) begin
      errors++;
      $display("FAIL basic_product: got %h want 0015", p);
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 4", lat);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_return_idle: got in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_corners();
    logic [7:0]  av[3] = '{8'h80, 8'h80, 8'h00};
    logic [7:0]  bv[3] = '{8'h80, 8'h7F, 8'hFF};
    logic [15:0] ev[3] = '{16'h4000, 16'hC080, 16'h0000};
    logic [15:0] p;
    int lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], 0, p, lat, to);
      checks++;
      if (to || p !== ev[i]) begin
        errors++;
        $display("FAIL corner_%0d: got %h (timeout=%b) want %h", i, p, to, ev[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    mcand = 8'hFB;
    mplier = 8'h09;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    mcand = 8'h02;
    mplier = 8'h03;
    guard = 0;
    while (!out_valid && guard < 20) begin
      step();
      guard++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_timeout: got out_valid=%b want 1", out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (product !== 16'hFFD3 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got product=%h ov=%b ir=%b want FFD3 1 0",
                 i, product, out_valid, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'hFFD3) begin
      errors++;
      $display("FAIL bp_release: got ir=%b ov=%b product=%h want 1 0 FFD3",
               in_ready, out_valid, product);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    int lat;
    bit to;
    mcand = 8'd3;
    mplier = 8'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset: got ir=%b ov=%b product=%h want 1 0 0000",
               in_ready, out_valid, product);
    end
    run_op(8'd5, 8'hFA, 0, p, lat, to);
    checks++;
    if (to || p !== 16'hFFE2) begin
      errors++;
      $display("FAIL mid_reset_next: got %h (timeout=%b) want FFE2", p, to);
    end
  endtask

  task automatic test_sweep();
    logic [7:0]  vals[12] = '{8'h80, 8'h81, 8'hFE, 8'hFF, 8'h00, 8'h01,
                              8'h02, 8'h7F, 8'h7E, 8'h55, 8'hAA, 8'hC3};
    logic [15:0] p;
    logic [15:0] exp_p;
    logic [7:0]  a;
    logic [7:0]  b;
    int lat;
    bit to;
    for (int k = 0; k < 244; k++) begin
      if (k < 144) begin
        a = vals[k / 12];
        b = vals[k % 12];
      end else begin
        a = 8'($urandom_range(255));
        b = 8'($urandom_range(255));
      end
      exp_p = 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b}));
      run_op(a, b, 30, p, lat, to);
      checks++;
      if (to || p !== exp_p || lat != 4) begin
        errors++;
        $display("FAIL sweep a=%h b=%h: got %h lat=%0d (timeout=%b) want %h lat=4",
                 a, b, p, lat, to, exp_p);
      end
    end
  endtask

`ifdef BOOTH_UNSIGNED_EN
  task automatic test_unsigned();
    logic [15:0] p;
    int lat;
    bit to;
    op_signed = 1'b0;
    run_op(8'hFF, 8'hFF, 0, p, lat, to);
    checks++;
    if (to || p !== 16'hFE01 || lat != 5) begin
      errors++;
      $display("FAIL unsigned_ff: got %h lat=%0d want FE01 lat=5", p, lat);
    end
    run_op(8'hC8, 8'h96, 20, p, lat, to);
    checks++;
    if (to || p !== 16'h7530) begin
      errors++;
      $display("FAIL unsigned_200x150: got %h want 7530", p);
    end
    op_signed = 1'b1;
    run_op(8'hFF, 8'hFF, 0, p, lat, to);
    checks++;
    if (to || p !== 16'h0001 || lat != 4) begin
      errors++;
      $display("FAIL signed_ff: got %h lat=%0d want 0001 lat=4", p, lat);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_sweep();
`ifdef BOOTH_UNSIGNED_EN
    test_unsigned();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
